// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-ported memory among N_REQ
// requesters: latches one command, holds it until mem_ack, then pulses resp.
module mem_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          resp,
  output logic [N_REQ*DATA_W-1:0]   rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  logic                found;
  logic [IDX_W-1:0]    sel;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [IDX_W:0]      cand;

  // Scan rr_ptr, rr_ptr+1, ... mod N_REQ; the inner loop keeps all indices constant.
  always_comb begin
    found     = 1'b0;
    sel       = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ))
        cand = cand - (IDX_W+1)'(N_REQ);
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (cand == (IDX_W+1)'(j))) begin
          found     = 1'b1;
          sel       = IDX_W'(j);
          sel_we    = we[j];
          sel_addr  = addr[j*ADDR_W +: ADDR_W];
          sel_wdata = wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)   state_nxt = ISSUE;
      ISSUE:   if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant_id  <= sel;
        cmd_we    <= sel_we;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
      end
      if (state == ISSUE && mem_ack && !cmd_we) begin
        for (int unsigned i = 0; i < N_REQ; i++)
          if (grant_id == IDX_W'(i))
            rdata[i*DATA_W +: DATA_W] <= mem_rdata;
      end
      if (state == RESP)
        rr_ptr <= (grant_id == IDX_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    resp = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      resp[i] = (state == RESP) && (grant_id == IDX_W'(i));
  end

  assign mem_req   = (state == ISSUE);
  assign mem_we    = cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single-ported coherent memory subsystem among the processor requesters.
- Accepts a read or write request from each processor and grants one at a time, fair rotation.
- Drives one command to the memory port, waits for its acknowledge, and returns read data plus a one-cycle response pulse to the granted processor.
- Sits between the processor request ports and the memory subsystem.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 14, address width.
- DATA_W, 16, data width (DATA_SIZE*8).
- IDX_W, $clog2(N_REQ), width of the requester index.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-processor request, level, held until resp.
- we  input  N_REQ  per-processor write enable (1 = write, 0 = read); sampled with req.
- addr  input  N_REQ*ADDR_W  per-processor address; slice i is requester i.
- wdata  input  N_REQ*DATA_W  per-processor write data.
- resp  output  N_REQ  one-cycle completion pulse per processor.
- rdata  output  N_REQ*DATA_W  per-processor read data, valid in the resp cycle.
- mem_req  output  1  command valid to memory.
- mem_we  output  1  command is a write.
- mem_addr  output  ADDR_W  command address.
- mem_wdata  output  DATA_W  command write data.
- mem_ack  input  1  memory completion, one-cycle pulse.
- mem_rdata  input  DATA_W  read data, valid with mem_ack.
- busy  output  1  high in every state except IDLE.
- grant_id  output  IDX_W  index of the current or last granted requester.

Behaviour:
- Reset (reset high at a clock edge):
  - state = IDLE; rr_ptr = 0; grant_id = 0.
  - resp = 0; rdata = 0; mem_req, mem_we, mem_addr and mem_wdata all 0; busy = 0.
  - Reset has priority over every other event.
- Reset mid-transaction: the FSM abandons the command and mem_req drops the next cycle. No resp is issued. The memory must tolerate the abandoned command.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ. Latch its index into grant_id and its we/addr/wdata into command registers, then go to ISSUE. If no req bit is set, stay in IDLE.
  - ISSUE: mem_req = 1 and mem_we/mem_addr/mem_wdata = latched command, held stable until mem_ack.
    - On mem_ack: capture mem_rdata (reads only) into rdata slice grant_id, then go to RESP.
    - mem_ack is valid in the first ISSUE cycle.
    - mem_ack outside ISSUE is ignored.
  - RESP: resp[grant_id] = 1 for exactly one cycle; mem_req = 0; rr_ptr = (grant_id+1) mod N_REQ; next state IDLE.
- Latency:
  - req sampled at edge T: mem_req is high in cycle T+1.
  - With mem_ack in cycle T+1, resp pulses in cycle T+2.
  - Minimum 3 cycles per transaction (IDLE -> ISSUE -> RESP).
- Handshake rules:
  - A requester holds req and its inputs stable until it sees resp, then drops req in the following cycle.
  - If req is still high in the IDLE cycle after RESP, it is treated as a new request, subject to the rotated pointer.
  - Requester inputs changing after grant have no effect; the command is latched in IDLE.
  - If req drops after grant, the transaction still completes and resp is still pulsed.
- rdata slices hold their last value until overwritten by that requester's next read. Writes do not modify rdata.
- Fairness: with all N_REQ requesters asserting continuously, the grant order is 0,1,2,...,N_REQ-1,0,... and no requester waits more than N_REQ-1 transactions.
- Simultaneous requests are resolved only by rr_ptr. There is no fixed priority.
- Wrap-around: rr_ptr = N_REQ-1 followed by a grant wraps rr_ptr to 0.
- Only one resp bit is ever high in a cycle. mem_req is never high in IDLE or RESP.

Test Plan:
- Reset then single read: req=0001, we=0, addr_0=5, memory returns mem_rdata=6 with ack one cycle after mem_req -> mem_addr=5, mem_we=0; resp=0001 one cycle; rdata slice0=6; total 3 cycles; busy low afterward.
- Single write by requester 2: addr=3, wdata=0xBEEF, mem_ack delayed 4 cycles -> mem_req held high for 5 cycles with mem_wdata=0xBEEF stable; resp=0100 once; rdata slice2 unchanged.
- All four requesting continuously from reset -> grant_id sequence 0,1,2,3,0,1; exactly one resp bit per transaction; each resp 3 cycles apart.
- Requests 1 and 3 asserted simultaneously with rr_ptr=2 -> grant 3 first, then 1; rr_ptr then equals 2.
- Reset asserted during ISSUE with mem_ack withheld -> mem_req=0 the next cycle; no resp; rr_ptr=0; the next request from requester 1 is granted normally.
- Spurious mem_ack in IDLE, and a requester dropping req during ISSUE -> spurious ack ignored; in-flight transaction completes; resp still pulses for the original requester.
